// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared constants, FSM state encoding and the line-address
//                helper for the direct-mapped instruction cache.
//                Ports: none (package).
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Line geometry: 16-byte lines, four 32-bit words per line.
    localparam int LINE_BYTES     = 16;
    localparam int OFFSET_W       = 4;
    localparam int WORD_SEL_LSB   = 2;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = LINE_BYTES / (WORD_W / 8);
    localparam int WORD_SEL_W     = 2;
    localparam int LINE_W         = LINE_BYTES * 8;
    localparam int PKG_ADDR_W     = 32;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    // Clears the byte-offset bits, giving the 16-byte-aligned line address.
    function automatic logic [PKG_ADDR_W-1:0] line_addr(input logic [PKG_ADDR_W-1:0] addr);
        return {addr[PKG_ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_line_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_line_array
//  Description : Valid/tag/data storage for the direct-mapped cache.
//                Combinational read port, one synchronous write port and a
//                synchronous clear of every valid bit.
//  Ports       : clk                         - clock
//                clr                         - clear all valid bits (flush/reset)
//                rd_idx / rd_valid / rd_tag / rd_line - read port
//                we / wr_idx / wr_tag / wr_line        - write port
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_line_array
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    // Only the valid bits carry state that matters after a clear; tag and
    // data contents are don't-care until their valid bit is set again.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid <= '0;
        end else if (we) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // A clear in the same cycle as a write suppresses the write entirely.
    always_ff @(posedge clk) begin
        if (we && !clr) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_line  = r_data[rd_idx];

endmodule : icache_line_array
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped read-only instruction cache. Serves 32-bit
//                words to fetch on a hit in the same cycle; on a miss it
//                stalls fetch, requests the 16-byte line from the line ROM
//                and fills the indexed entry when the ROM answers.
//  Ports       : clk, rst_n (sync, active low)
//                pc_i, fetch_req_i, flush_i          - fetch side inputs
//                inst_o, inst_valid_o, stall_o       - fetch side outputs
//                Icache_addr_o, Icache_valid_req_o   - line request
//                mem_data_i, mem_ready_i             - line response
//  Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              fetch_req_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] Icache_addr_o,
    output logic              Icache_valid_req_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ready_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_refill_addr;

    logic [IDX_W-1:0]    w_rd_idx;
    logic [TAG_W-1:0]    w_pc_tag;
    logic                w_rd_valid;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [LINE_W-1:0]   w_rd_line;
    logic [WORD_SEL_W-1:0] w_word_sel;
    logic                w_hit;
    logic                w_start_refill;
    logic                w_we;
    logic                w_clr;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [TAG_W-1:0]    w_wr_tag;
    logic [ADDR_W-1:0]   w_pc_line;
    logic                w_unused_pc;

    // Byte-within-word bits of the PC never affect the lookup.
    assign w_unused_pc = &{1'b0, pc_i[WORD_SEL_LSB-1:0]};

    // ------------------------------------------------------------------
    // Lookup (combinational on pc_i)
    // ------------------------------------------------------------------
    assign w_rd_idx   = pc_i[OFFSET_W +: IDX_W];
    assign w_pc_tag   = pc_i[ADDR_W-1 -: TAG_W];
    assign w_word_sel = pc_i[WORD_SEL_LSB +: WORD_SEL_W];
    assign w_pc_line  = line_addr(pc_i);

    // A hit is only honoured in IDLE, outside a flush and outside reset, so
    // a line cleared on this edge can never be served in the same cycle.
    assign w_hit = fetch_req_i & w_rd_valid & (w_rd_tag == w_pc_tag)
                 & ~flush_i & rst_n & (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Refill write port: always targets the latched address, not pc_i,
    // because fetch may move pc_i while the refill is outstanding.
    // ------------------------------------------------------------------
    assign w_wr_idx = r_refill_addr[OFFSET_W +: IDX_W];
    assign w_wr_tag = r_refill_addr[ADDR_W-1 -: TAG_W];
    assign w_clr    = flush_i | ~rst_n;

    icache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .clr      (w_clr),
        .rd_idx   (w_rd_idx),
        .rd_valid (w_rd_valid),
        .rd_tag   (w_rd_tag),
        .rd_line  (w_rd_line),
        .we       (w_we),
        .wr_idx   (w_wr_idx),
        .wr_tag   (w_wr_tag),
        .wr_line  (mem_data_i)
    );

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_refill_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_refill) begin
                r_refill_addr <= w_pc_line;
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_start_refill     = 1'b0;
        w_we               = 1'b0;
        inst_o             = '0;
        inst_valid_o       = 1'b0;
        stall_o            = 1'b0;
        Icache_valid_req_o = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    inst_o       = w_rd_line[WORD_W*w_word_sel +: WORD_W];
                    inst_valid_o = 1'b1;
                end
                stall_o = fetch_req_i & ~w_hit;
                // Any mem_ready_i seen here is a late echo of the previous
                // refill and is deliberately ignored.
                if (fetch_req_i && !w_hit && !flush_i) begin
                    w_start_refill = 1'b1;
                    w_state_next   = ST_REFILL;
                end
            end
            ST_REFILL: begin
                Icache_valid_req_o = 1'b1;
                stall_o            = 1'b1;
                if (mem_ready_i && !flush_i) begin
                    w_we         = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Flush abandons any outstanding refill; its response is dropped.
        if (flush_i) begin
            w_state_next = ST_IDLE;
        end

        // While reset is asserted nothing is requested, served or written.
        if (!rst_n) begin
            w_we               = 1'b0;
            inst_o             = '0;
            inst_valid_o       = 1'b0;
            stall_o            = 1'b0;
            Icache_valid_req_o = 1'b0;
        end
    end

    assign Icache_addr_o = r_refill_addr;

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache
//  Description : Self-checking bench for icache. A line-ROM responder answers
//                one cycle after seeing a request (optionally echoing one
//                extra stale beat); expected words and request addresses are
//                queued at issue time and checked by independent monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  pc;
    logic         fetch_req;
    logic         flush;
    logic [31:0]  inst;
    logic         inst_valid;
    logic         stall;
    logic [31:0]  req_addr;
    logic         req;
    logic [127:0] mem_data = '0;
    logic         mem_ready = 1'b0;

    always #5 clk = ~clk;

    icache #(.LINES(16), .ADDR_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pc_i               (pc),
        .fetch_req_i        (fetch_req),
        .flush_i            (flush),
        .inst_o             (inst),
        .inst_valid_o       (inst_valid),
        .stall_o            (stall),
        .Icache_addr_o      (req_addr),
        .Icache_valid_req_o (req),
        .mem_data_i         (mem_data),
        .mem_ready_i        (mem_ready)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_inst[$];   // expected instruction words, in order
    logic [31:0] q_req[$];    // expected line-request addresses, in order
    logic [31:0] cached[int]; // reference: index -> resident line address
    bit          stale_mode = 1'b0;

    // Line ROM contents. Line 0 holds the recognisable pattern 1111.../4444...
    function automatic logic [31:0] rom_word(input logic [31:0] la, input int k);
        logic [31:0] kk;
        kk = k;
        if (la == 32'h0) return 32'h1111_1111 * (kk + 32'd1);
        return (la * 32'h9E37_79B1) ^ (32'h0123_4567 << kk) ^ kk;
    endfunction

    function automatic logic [127:0] rom_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = rom_word(la, k);
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- instruction monitor ----------------
    always @(negedge clk) begin
        if (inst_valid === 1'b1) begin
            if (q_inst.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_inst actual=%h required=none", inst);
            end else begin
                check("inst", inst, q_inst.pop_front());
            end
        end
    end

    // ---------------- request monitor + ROM responder ----------------
    logic        seen_req = 1'b0;
    logic [31:0] seen_addr = '0;
    logic        answered = 1'b0;
    logic        stale_pending = 1'b0;
    logic [31:0] answered_addr = '0;

    always @(negedge clk) begin
        if (req === 1'b1) begin
            if (!seen_req) begin
                if (q_req.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_request actual=%h required=none", req_addr);
                end else begin
                    check("req_addr", req_addr, q_req.pop_front());
                end
            end else begin
                check("req_addr_stable", req_addr, seen_addr);
            end
        end
        seen_req  = (req === 1'b1);
        seen_addr = req_addr;
    end

    always @(posedge clk) begin
        #1;
        if (seen_req && !answered) begin
            mem_ready     = 1'b1;
            mem_data      = rom_line(seen_addr);
            answered      = 1'b1;
            answered_addr = seen_addr;
            stale_pending = stale_mode;
        end else if (stale_pending) begin
            // Late echo with corrupted data: must never land in the array.
            mem_ready     = 1'b1;
            mem_data      = ~rom_line(answered_addr);
            stale_pending = 1'b0;
            answered      = 1'b0;
        end else begin
            mem_ready = 1'b0;
            mem_data  = {$urandom, $urandom, $urandom, $urandom};
            answered  = 1'b0;
        end
    end

    // ---------------- stimulus tasks (start/end at posedge+1) ----------------
    task automatic do_fetch(input logic [31:0] a);
        logic [31:0] la;
        int          idx;
        bit          hit;
        int          lat;
        la  = {a[31:4], 4'b0};
        idx = int'(a[7:4]);
        hit = cached.exists(idx) && (cached[idx] == la);
        pc = a; fetch_req = 1'b1; flush = 1'b0;
        q_inst.push_back(rom_word(la, int'(a[3:2])));
        if (!hit) begin
            q_req.push_back(la);
            cached[idx] = la;
        end
        lat = 0;
        forever begin
            @(negedge clk);
            if (inst_valid === 1'b1) break;
            check("miss_stall", {31'b0, stall}, 32'd1);
            check("miss_inst_zero", inst, 32'd0);
            lat++;
            if (lat > 20) break;
            @(posedge clk); #1;
        end
        check("latency", lat, hit ? 32'd0 : 32'd3);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle(input bit do_flush);
        pc = $urandom; fetch_req = do_flush; flush = do_flush;
        @(negedge clk);
        check("idle_stall", {31'b0, stall}, {31'b0, do_flush});
        check("idle_valid", {31'b0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; fetch_req = 1'b0;
        if (do_flush) cached.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; pc = '0; fetch_req = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_inst", inst, 32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_addr", req_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First miss and word hits in the same line.
        do_fetch(32'h0000_0004);
        check("model_word1", q_inst.size(), 32'd0);
        do_fetch(32'h0000_0000);
        do_fetch(32'h0000_0008);
        do_fetch(32'h0000_000C);

        // Index aliasing: 0x100 evicts 0x0.
        do_fetch(32'h0000_0100);
        do_fetch(32'h0000_0000);

        // Stale ready after completion must not overwrite the line.
        stale_mode = 1'b1;
        do_fetch(32'h0000_0040);
        stale_mode = 1'b0;
        do_fetch(32'h0000_0044);

        // Flush coincident with mem_ready during REFILL.
        pc = 32'h0000_0080; fetch_req = 1'b1;
        q_req.push_back(32'h0000_0080);
        @(negedge clk);
        check("flush_t_stall0", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_t_req1", {31'b0, req}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b1; fetch_req = 1'b0;
        @(negedge clk);
        check("flush_t_stall2", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        cached.delete();
        @(negedge clk);
        check("flush_t_req_after", {31'b0, req}, 32'd0);
        check("flush_t_stall_after", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        do_fetch(32'h0000_0080);
        do_fetch(32'h0000_0044);

        // Reset while REFILL is waiting on the ROM.
        pc = 32'h0000_0090; fetch_req = 1'b1;
        q_req.push_back(32'h0000_0090);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_t_req1", {31'b0, req}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; fetch_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cached.delete();
        @(negedge clk);
        check("rst_t_req_after", {31'b0, req}, 32'd0);
        @(posedge clk); #1;
        do_fetch(32'h0000_0090);
        do_fetch(32'h0000_0084);

        // Randomised traffic over 48 lines (3 tags per index).
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                idle_cycle(1'b0);
            end else if (r < 8) begin
                idle_cycle(1'b1);
            end else begin
                logic [31:0] line_no;
                logic [31:0] a;
                line_no    = $urandom_range(0, 47);
                a          = (line_no << 4) | ($urandom_range(0, 15));
                stale_mode = ($urandom_range(0, 3) == 0);
                do_fetch(a);
                stale_mode = 1'b0;
            end
        end

        fetch_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("inst_queue_empty", q_inst.size(), 32'd0);
        check("req_queue_empty", q_req.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_icache
`default_nettype wire
